// File: rtl/mac_operand_sequencer.sv
// Job-level initiator for one MAC block: takes a job descriptor, streams operand
// beats into the MAC, waits out its one-cycle latency and returns the final C value.
module mac_operand_sequencer #(
   parameter int MIN_WIDTH  = 8,
   parameter int ACC_WIDTH  = 4*MIN_WIDTH,
   parameter int CONF_WIDTH = 3,
   parameter int LEN_WIDTH  = 8
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            job_valid,
   output logic                            job_ready,
   input  logic [CONF_WIDTH-1:0]           job_cfg,
   input  logic [ACC_WIDTH-1:0]            job_init,
   input  logic [LEN_WIDTH-1:0]            job_len,
   input  logic                            op_valid,
   output logic                            op_ready,
   input  logic [4*MIN_WIDTH-1:0]          op_a,
   input  logic [MIN_WIDTH-1:0]            op_b,
   output logic [MIN_WIDTH-1:0]            mac_a0,
   output logic [MIN_WIDTH-1:0]            mac_a1,
   output logic [MIN_WIDTH-1:0]            mac_a2,
   output logic [MIN_WIDTH-1:0]            mac_a3,
   output logic [MIN_WIDTH-1:0]            mac_b2,
   output logic [ACC_WIDTH+CONF_WIDTH-1:0] mac_cfg,
   output logic                            mac_en,
   output logic                            mac_clr,
   input  logic [ACC_WIDTH-1:0]            mac_c,
   output logic                            res_valid,
   input  logic                            res_ready,
   output logic [ACC_WIDTH-1:0]            res_data,
   output logic                            res_err,
   output logic                            busy
);
   localparam int OPW = 4*MIN_WIDTH;

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_STREAM, S_DRAIN, S_RESP} state_t;

   state_t                state_q, state_d;
   logic [CONF_WIDTH-1:0] cfg_q, cfg_d;
   logic [ACC_WIDTH-1:0]  init_q, init_d;
   logic [LEN_WIDTH-1:0]  len_q, len_d;
   logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
   logic [OPW-1:0]        opa_q, opa_d;
   logic [MIN_WIDTH-1:0]  opb_q, opb_d;
   logic [ACC_WIDTH-1:0]  res_data_q, res_data_d;
   logic                  res_err_q, res_err_d;

   logic           fire;
   logic           mode_rsv;
   logic           acc_sel;
   logic [OPW-1:0] lane_src;

   assign fire     = (state_q == S_STREAM) && op_valid;
   assign mode_rsv = (cfg_q[1:0] == 2'b11);
   assign acc_sel  = cfg_q[CONF_WIDTH-1];

   always_comb begin
      state_d    = state_q;
      cfg_d      = cfg_q;
      init_d     = init_q;
      len_d      = len_q;
      cnt_d      = cnt_q;
      opa_d      = opa_q;
      opb_d      = opb_q;
      res_data_d = res_data_q;
      res_err_d  = res_err_q;
      case (state_q)
         S_IDLE: begin
            if (job_valid) begin
               cfg_d   = job_cfg;
               init_d  = job_init;
               len_d   = job_len;
               state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            cnt_d   = len_q;
            state_d = (len_q != '0) ? S_STREAM : S_DRAIN;
         end
         S_STREAM: begin
            if (fire) begin
               cnt_d = cnt_q - 1'b1;
               opa_d = op_a;
               opb_d = op_b;
               if (cnt_q == LEN_WIDTH'(1)) state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            // mac_c already reflects the last fire; zero-length jobs never touched the MAC
            res_err_d = mode_rsv;
            if (mode_rsv)             res_data_d = '0;
            else if (len_q == '0)     res_data_d = acc_sel ? init_q : '0;
            else                      res_data_d = mac_c;
            state_d = S_RESP;
         end
         S_RESP: begin
            if (res_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= S_IDLE;
         cfg_q      <= '0;
         init_q     <= '0;
         len_q      <= '0;
         cnt_q      <= '0;
         opa_q      <= '0;
         opb_q      <= '0;
         res_data_q <= '0;
         res_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cfg_q      <= cfg_d;
         init_q     <= init_d;
         len_q      <= len_d;
         cnt_q      <= cnt_d;
         opa_q      <= opa_d;
         opb_q      <= opb_d;
         res_data_q <= res_data_d;
         res_err_q  <= res_err_d;
      end
   end

   // Operands pass straight through on a fire, otherwise hold the last beat driven
   assign lane_src = fire ? op_a : opa_q;
   assign mac_a0   = lane_src[0*MIN_WIDTH +: MIN_WIDTH];
   assign mac_a1   = lane_src[1*MIN_WIDTH +: MIN_WIDTH];
   assign mac_a2   = lane_src[2*MIN_WIDTH +: MIN_WIDTH];
   assign mac_a3   = lane_src[3*MIN_WIDTH +: MIN_WIDTH];
   assign mac_b2   = fire ? op_b : opb_q;

   assign mac_en    = fire;
   assign mac_clr   = (state_q == S_LOAD);
   assign mac_cfg   = (state_q == S_LOAD || state_q == S_STREAM || state_q == S_DRAIN) ?
                      {init_q, cfg_q} : '0;
   assign job_ready = (state_q == S_IDLE);
   assign op_ready  = (state_q == S_STREAM);
   assign res_valid = (state_q == S_RESP);
   assign busy      = (state_q != S_IDLE);
   assign res_data  = res_data_q;
   assign res_err   = res_err_q;
endmodule

// File: tb/tb_mac_operand_sequencer.sv
// Bench for mac_operand_sequencer: behavioural MAC on the far side, job-level
// reference model, table vectors, reset/long-job sequences and random jobs.
module tb_mac_operand_sequencer;
   localparam int MW = 8, AW = 32, CW = 3, LW = 8;

   logic          clk = 1'b0, rst = 1'b0;
   logic          job_valid = 1'b0, job_ready;
   logic [CW-1:0] job_cfg = '0;
   logic [AW-1:0] job_init = '0;
   logic [LW-1:0] job_len = '0;
   logic          op_valid = 1'b0, op_ready;
   logic [4*MW-1:0] op_a = '0;
   logic [MW-1:0] op_b = '0;
   logic [MW-1:0] mac_a0, mac_a1, mac_a2, mac_a3, mac_b2;
   logic [AW+CW-1:0] mac_cfg;
   logic          mac_en, mac_clr;
   logic [AW-1:0] mac_c;
   logic          res_valid, res_ready = 1'b0, res_err, busy;
   logic [AW-1:0] res_data;

   always #5 clk = ~clk;

   mac_operand_sequencer #(.MIN_WIDTH(MW), .ACC_WIDTH(AW), .CONF_WIDTH(CW), .LEN_WIDTH(LW)) dut (
      .clk(clk), .rst(rst), .job_valid(job_valid), .job_ready(job_ready), .job_cfg(job_cfg),
      .job_init(job_init), .job_len(job_len), .op_valid(op_valid), .op_ready(op_ready),
      .op_a(op_a), .op_b(op_b), .mac_a0(mac_a0), .mac_a1(mac_a1), .mac_a2(mac_a2),
      .mac_a3(mac_a3), .mac_b2(mac_b2), .mac_cfg(mac_cfg), .mac_en(mac_en), .mac_clr(mac_clr),
      .mac_c(mac_c), .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
      .res_err(res_err), .busy(busy));

   // Per-beat MAC product; reserved mode yields garbage so the sequencer must override it
   function automatic logic [31:0] prod(input logic [1:0] mode, input logic [31:0] a, input logic [7:0] b);
      logic [31:0] p0, p1, p2, p3;
      p0 = 32'(a[7:0]) * 32'(b);
      p1 = 32'(a[15:8]) * 32'(b);
      p2 = 32'(a[23:16]) * 32'(b);
      p3 = 32'(a[31:24]) * 32'(b);
      case (mode)
         2'd0:    return p2;
         2'd1:    return p2 + (p3 << 8);
         2'd2:    return p0 + (p1 << 8) + (p2 << 16) + (p3 << 24);
         default: return 32'hFFFF_FFFF;
      endcase
   endfunction

   logic [AW-1:0] acc;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) acc <= '0;
      else if (mac_clr) acc <= mac_cfg[CW-1] ? mac_cfg[AW+CW-1:CW] : '0;
      else if (mac_en)
         acc <= mac_cfg[CW-1] ? acc + prod(mac_cfg[1:0], {mac_a3, mac_a2, mac_a1, mac_a0}, mac_b2)
                              : prod(mac_cfg[1:0], {mac_a3, mac_a2, mac_a1, mac_a0}, mac_b2);
   end
   assign mac_c = acc;

   int cyc = 0, en_cnt = 0, clr_cnt = 0;
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (rst && mac_en)  en_cnt <= en_cnt + 1;
      if (rst && mac_clr) clr_cnt <= clr_cnt + 1;
   end

   int checks = 0, errors = 0;
   logic [31:0] qa[$];
   logic [7:0]  qb[$];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk); #1;
   endtask

   // Job-level reference: result depends only on mode, accumulate flag, init and the beat list
   function automatic logic [32:0] ref_job(input logic [2:0] cfg, input logic [31:0] init);
      logic [31:0] r;
      if (cfg[1:0] == 2'b11) return {1'b1, 32'd0};
      if (qa.size() == 0) return {1'b0, cfg[2] ? init : 32'd0};
      r = cfg[2] ? init : 32'd0;
      for (int i = 0; i < qa.size(); i++)
         r = cfg[2] ? r + prod(cfg[1:0], qa[i], qb[i]) : prod(cfg[1:0], qa[i], qb[i]);
      return {1'b0, r};
   endfunction

   task automatic do_reset();
      #2 rst = 1'b0;
      #3 rst = 1'b1;
      step();
   endtask

   task automatic run_job(input logic [2:0] cfg, input logic [31:0] init, input int gap, input int hold,
                          input logic [31:0] exp_d, input logic exp_e, input string nm);
      int len, w, j, k, en0, clr0;
      logic opr_seen;
      len = qa.size();
      en0 = en_cnt; clr0 = clr_cnt;
      chk({nm, ".job_ready"}, 64'(job_ready), 64'd1);
      job_valid = 1'b1; job_cfg = cfg; job_init = init; job_len = LW'(len); j = cyc;
      step();
      job_valid = 1'b0;
      chk({nm, ".load_clr"}, 64'(mac_clr), 64'd1);
      chk({nm, ".load_cfg"}, 64'(mac_cfg), 64'({init, cfg}));
      k = j + 1;
      if (len > 0) begin
         w = 0;
         while (!op_ready && w < 8) begin step(); w++; end
         chk({nm, ".op_ready_lat"}, 64'(cyc - j), 64'd2);
         for (int i = 0; i < len; i++) begin
            op_valid = 1'b1; op_a = qa[i]; op_b = qb[i];
            #1;
            chk($sformatf("%s.en_beat%0d", nm, i), 64'(mac_en), 64'd1);
            chk($sformatf("%s.ops_beat%0d", nm, i), 64'({mac_a3, mac_a2, mac_a1, mac_a0, mac_b2}),
                64'({qa[i], qb[i]}));
            k = cyc;
            step();
            op_valid = 1'b0;
            if (gap != 0 && i < len - 1) begin
               #1;
               chk($sformatf("%s.idle_en%0d", nm, i), 64'(mac_en), 64'd0);
               chk($sformatf("%s.hold_ops%0d", nm, i), 64'({mac_a3, mac_a2, mac_a1, mac_a0, mac_b2}),
                   64'({qa[i], qb[i]}));
               step();
            end
         end
      end
      w = 0; opr_seen = 1'b0;
      while (!res_valid && w < 12) begin opr_seen |= op_ready; step(); w++; end
      if (len == 0) chk({nm, ".no_op_ready"}, 64'(opr_seen), 64'd0);
      chk({nm, ".res_valid"}, 64'(res_valid), 64'd1);
      chk({nm, ".res_lat"}, 64'(cyc - k), 64'd2);
      chk({nm, ".res_data"}, 64'(res_data), 64'(exp_d));
      chk({nm, ".res_err"}, 64'(res_err), 64'(exp_e));
      chk({nm, ".en_count"}, 64'(en_cnt - en0), 64'(len));
      chk({nm, ".clr_count"}, 64'(clr_cnt - clr0), 64'd1);
      for (int h = 0; h < hold; h++) begin
         op_valid = 1'b1;
         step();
         chk($sformatf("%s.hold%0d", nm, h), 64'({res_valid, job_ready, mac_en, res_err, res_data}),
             64'({1'b1, 1'b0, 1'b0, exp_e, exp_d}));
      end
      op_valid = 1'b0; res_ready = 1'b1;
      step();
      res_ready = 1'b0;
      chk({nm, ".post_accept"}, 64'({res_valid, job_ready}), 64'b01);
      if (!job_ready) do_reset();
      qa.delete(); qb.delete();
   endtask

   typedef struct packed {
      logic [2:0]       cfg;
      logic [31:0]      init;
      int               len;
      logic [3:0][31:0] a;
      logic [3:0][7:0]  b;
      int               gap;
      int               hold;
      logic [31:0]      exp_d;
      logic             exp_e;
   } vec_t;

   function automatic vec_t mk(input logic [2:0] cfg, input logic [31:0] init, input int len,
                               input logic [31:0] a0, a1, a2, a3, input logic [7:0] b0, b1, b2, b3,
                               input int gap, input int hold, input logic [31:0] exp_d, input logic exp_e);
      vec_t v;
      v.cfg = cfg; v.init = init; v.len = len;
      v.a = {a3, a2, a1, a0}; v.b = {b3, b2, b1, b0};
      v.gap = gap; v.hold = hold; v.exp_d = exp_d; v.exp_e = exp_e;
      return v;
   endfunction

   vec_t tbl[8];

   initial begin
      tbl[0] = mk(3'b000, 32'd0, 1, 32'h0003_0000, 0, 0, 0, 8'd5, 0, 0, 0, 0, 0, 32'd15, 1'b0);
      tbl[1] = mk(3'b001, 32'd0, 1, 32'h0102_0000, 0, 0, 0, 8'd3, 0, 0, 0, 0, 5, 32'h0306, 1'b0);
      tbl[2] = mk(3'b110, 32'd10, 3, 32'h1, 32'h1, 32'h1, 0, 8'd1, 8'd1, 8'd1, 0, 1, 0, 32'd13, 1'b0);
      tbl[3] = mk(3'b100, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hDEAD_BEEF, 1'b0);
      tbl[4] = mk(3'b000, 32'h1234, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'd0, 1'b0);
      tbl[5] = mk(3'b111, 32'h55, 2, 32'h0101_0101, 32'h0202_0202, 0, 0, 8'd7, 8'd9, 0, 0, 0, 2, 32'd0, 1'b1);
      tbl[6] = mk(3'b100, 32'd100, 2, 32'h0004_0000, 32'h0002_0000, 0, 0, 8'd2, 8'd3, 0, 0, 1, 0, 32'd114, 1'b0);
      tbl[7] = mk(3'b000, 32'd77, 2, 32'h0007_0000, 32'h0002_0000, 0, 0, 8'd9, 8'd2, 0, 0, 0, 0, 32'd4, 1'b0);

      #1;
      chk("reset_outputs", 64'({job_ready, op_ready, busy, res_valid, mac_en, mac_clr, res_err}), 64'b1000000);
      chk("reset_data", 64'({mac_cfg, res_data}), 64'd0);
      #11 rst = 1'b1;
      step();

      for (int t = 0; t < 8; t++) begin
         for (int i = 0; i < tbl[t].len; i++) begin qa.push_back(tbl[t].a[i]); qb.push_back(tbl[t].b[i]); end
         run_job(tbl[t].cfg, tbl[t].init, tbl[t].gap, tbl[t].hold, tbl[t].exp_d, tbl[t].exp_e,
                 $sformatf("vec%0d", t));
      end

      // Reset after one of four beats: everything must drop at once, no result may appear
      job_valid = 1'b1; job_cfg = 3'b100; job_init = 32'd50; job_len = 8'd4;
      step(); job_valid = 1'b0;
      step();
      op_valid = 1'b1; op_a = 32'h0009_0000; op_b = 8'd9;
      step();
      #2 rst = 1'b0;
      #1;
      chk("midrst_ctrl", 64'({job_ready, op_ready, busy, res_valid, mac_en, mac_clr, res_err}), 64'b1000000);
      chk("midrst_data", 64'({mac_cfg, res_data, mac_a3, mac_a2, mac_a1, mac_a0}), 64'd0);
      op_valid = 1'b0;
      #3 rst = 1'b1;
      step();
      begin
         logic seen = 1'b0;
         for (int i = 0; i < 4; i++) begin seen |= res_valid | busy; step(); end
         chk("midrst_no_stale", 64'(seen), 64'd0);
      end
      qa.push_back(32'h0004_0000); qb.push_back(8'd4);
      run_job(3'b000, 32'd0, 0, 0, 32'd16, 1'b0, "after_rst");

      // Maximum beat count: counter must run all 255 beats without wrapping
      for (int i = 0; i < 255; i++) begin qa.push_back($urandom); qb.push_back(8'($urandom)); end
      begin
         logic [32:0] r;
         r = ref_job(3'b110, 32'h0000_1000);
         run_job(3'b110, 32'h0000_1000, 0, 0, r[31:0], r[32], "len255");
      end

      for (int n = 0; n < 30; n++) begin
         logic [2:0]  cfg;
         logic [31:0] init;
         logic [32:0] r;
         int len;
         cfg = 3'($urandom_range(0, 7));
         init = $urandom;
         len = $urandom_range(0, 5);
         for (int i = 0; i < len; i++) begin qa.push_back($urandom); qb.push_back(8'($urandom)); end
         r = ref_job(cfg, init);
         run_job(cfg, init, $urandom_range(0, 1), $urandom_range(0, 2), r[31:0], r[32],
                 $sformatf("rnd%0d", n));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
